// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-port data memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    localparam int MEM_DEPTH_DEF = 8;
    localparam int RD_LAT_DEF    = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the port that was not granted last wins.
// Purely combinational; a lone requester always wins.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       grant_valid_o
);

    always_comb begin
        grant_valid_o = |req_i;
        if (&req_i) begin
            grant_o = ~last_grant_i;
        end else begin
            grant_o = req_i[1] ? P1 : P0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one word-addressed data memory between a CPU port (0) and a loader port (1).
// Each access runs IDLE -> ACCESS -> RESP with a one-cycle ack; requests seen while busy wait for IDLE.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int RD_LAT    = RD_LAT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_err_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    localparam int CNT_W = 2;

    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic              last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic              legal_q, legal_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        ack_q, ack_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] rdata_q [2];
    logic [DATA_W-1:0] rdata_d [2];
    logic              gnt;
    logic              gnt_valid;
    logic [ADDR_W-1:0] req_addr;

    rr_arb2 u_rr_arb2 (
        .req_i        ({m1_req_i, m0_req_i}),
        .last_grant_i (last_grant_q),
        .grant_o      (gnt),
        .grant_valid_o(gnt_valid)
    );

    assign req_addr = gnt ? m1_addr_i : m0_addr_i;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        legal_d      = legal_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        ack_d        = '0;
        err_d        = '0;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    sel_d        = gnt;
                    last_grant_d = gnt;
                    we_d         = gnt ? m1_we_i : m0_we_i;
                    addr_d       = req_addr;
                    wdata_d      = gnt ? m1_wdata_i : m0_wdata_i;
                    legal_d      = req_addr < ADDR_W'(MEM_DEPTH);
                    // Strobes are registered, so they rise together with the ACCESS state.
                    mem_we_d     = legal_d && we_d;
                    mem_re_d     = legal_d && !we_d;
                    cnt_d        = '0;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (!legal_q || we_q) begin
                    ack_d[sel_q] = 1'b1;
                    err_d[sel_q] = !legal_q;
                    state_d      = RESP;
                end else if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                    rdata_d[sel_q] = mem_rdata_i;
                    ack_d[sel_q]   = 1'b1;
                    state_d        = RESP;
                end else begin
                    mem_re_d = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            sel_q        <= P0;
            last_grant_q <= P1;
            we_q         <= 1'b0;
            legal_q      <= 1'b0;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '{default: '0};
            ack_q        <= '0;
            err_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            legal_q      <= legal_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_we_o    = mem_we_q;
    assign mem_re_o    = mem_re_q;
    assign busy_o      = (state_q != IDLE);
    assign m0_ack_o    = ack_q[P0];
    assign m0_err_o    = err_q[P0];
    assign m0_rdata_o  = rdata_q[P0];
    assign m1_ack_o    = ack_q[P1];
    assign m1_err_o    = err_q[P1];
    assign m1_rdata_o  = rdata_q[P1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized two-port traffic,
// checked every cycle against a transaction-schedule model of the arbiter.
module tb_dmem_arbiter;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_init = 1'b1;
    always #5 clk = ~clk;

    logic        req [2];
    logic        we [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic        ack [2];
    logic        err [2];
    logic [31:0] rdata [2];
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re, busy;
    logic [31:0] mem [8];

    logic        d3_req [2];
    logic        d3_we [2];
    logic [31:0] d3_addr [2];
    logic [31:0] d3_wdata [2];
    logic        d3_ack [2];
    logic        d3_err [2];
    logic [31:0] d3_rdata [2];
    logic [31:0] d3_maddr, d3_mwdata, d3_mrdata;
    logic        d3_mwe, d3_mre, d3_busy;
    logic [31:0] mem3 [8];

    int chk  = 0;
    int errs = 0;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(8), .RD_LAT(RD_LAT)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]), .m0_wdata_i(wdata[0]),
        .m0_ack_o(ack[0]), .m0_rdata_o(rdata[0]), .m0_err_o(err[0]),
        .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]), .m1_wdata_i(wdata[1]),
        .m1_ack_o(ack[1]), .m1_rdata_o(rdata[1]), .m1_err_o(err[1]),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we), .mem_re_o(mem_re),
        .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(8), .RD_LAT(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(d3_req[0]), .m0_we_i(d3_we[0]), .m0_addr_i(d3_addr[0]), .m0_wdata_i(d3_wdata[0]),
        .m0_ack_o(d3_ack[0]), .m0_rdata_o(d3_rdata[0]), .m0_err_o(d3_err[0]),
        .m1_req_i(d3_req[1]), .m1_we_i(d3_we[1]), .m1_addr_i(d3_addr[1]), .m1_wdata_i(d3_wdata[1]),
        .m1_ack_o(d3_ack[1]), .m1_rdata_o(d3_rdata[1]), .m1_err_o(d3_err[1]),
        .mem_addr_o(d3_maddr), .mem_wdata_o(d3_mwdata), .mem_we_o(d3_mwe), .mem_re_o(d3_mre),
        .mem_rdata_i(d3_mrdata), .busy_o(d3_busy)
    );

    // Memory instances behind each arbiter: combinational read, write on the edge.
    assign mem_rdata  = (mem_addr < 32'd8) ? mem[mem_addr[2:0]] : 32'hBAD0_BAD0;
    assign d3_mrdata  = (d3_maddr < 32'd8) ? mem3[d3_maddr[2:0]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 8; i++) mem[i] <= 32'hA000_0000 + i;
        end else if (mem_we && mem_addr < 32'd8) begin
            mem[mem_addr[2:0]] <= mem_wdata;
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 8; i++) mem3[i] <= (i == 5) ? 32'h1234_5678 : 32'hC000_0000 + i;
        end else if (d3_mwe && d3_maddr < 32'd8) begin
            mem3[d3_maddr[2:0]] <= d3_mwdata;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every granted transaction expands into a fixed schedule of per-cycle outputs.
    typedef struct packed {
        logic        we;
        logic        re;
        logic        busy;
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } exp_t;

    exp_t        cur;
    exp_t        sched [$];
    int          last_g;
    int          grant_log [$];
    logic [31:0] mmem [8];

    task automatic model_grant();
        int   w;
        exp_t r;
        w = (req[0] && req[1]) ? 1 - last_g : (req[1] ? 1 : 0);
        last_g = w;
        grant_log.push_back(w);
        r = cur;
        r.busy = 1'b1; r.ack = '0; r.err = '0; r.we = 1'b0; r.re = 1'b0;
        r.addr = addr[w]; r.wdata = wdata[w];
        if (addr[w] >= 32'd8) begin
            sched.push_back(r);
            r.ack[w] = 1'b1; r.err[w] = 1'b1;
            sched.push_back(r);
        end else if (we[w]) begin
            r.we = 1'b1;
            sched.push_back(r);
            r.we = 1'b0; r.ack[w] = 1'b1;
            sched.push_back(r);
        end else begin
            r.re = 1'b1;
            repeat (RD_LAT) sched.push_back(r);
            r.re = 1'b0; r.ack[w] = 1'b1;
            if (w == 0) r.rd0 = mmem[addr[w][2:0]];
            else        r.rd1 = mmem[addr[w][2:0]];
            sched.push_back(r);
        end
        cur = sched.pop_front();
    endtask

    initial begin
        cur = '0;
        last_g = 1;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                sched.delete();
                cur = '0;
                last_g = 1;
                if (mem_init) for (int i = 0; i < 8; i++) mmem[i] = 32'hA000_0000 + i;
            end else begin
                if (cur.we) mmem[cur.addr[2:0]] = cur.wdata;
                if (sched.size() > 0) begin
                    cur = sched.pop_front();
                end else if (cur.busy || !(req[0] || req[1])) begin
                    cur.we = 1'b0; cur.re = 1'b0; cur.ack = '0; cur.err = '0; cur.busy = 1'b0;
                end else begin
                    model_grant();
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("cmp_we",    mem_we,    cur.we);
                check("cmp_re",    mem_re,    cur.re);
                check("cmp_busy",  busy,      cur.busy);
                check("cmp_addr",  mem_addr,  cur.addr);
                check("cmp_wdata", mem_wdata, cur.wdata);
                check("cmp_ack0",  ack[0],    cur.ack[0]);
                check("cmp_ack1",  ack[1],    cur.ack[1]);
                check("cmp_err0",  err[0],    cur.err[0]);
                check("cmp_err1",  err[1],    cur.err[1]);
                check("cmp_rd0",   rdata[0],  cur.rd0);
                check("cmp_rd1",   rdata[1],  cur.rd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input int n);
        int idle;
        int t;
        for (int i = 0; i < n; i++) begin
            idle = $urandom_range(0, 3);
            if (idle > 0) begin
                req[p] = 1'b0;
                repeat (idle) tick();
            end
            we[p]    = 1'($urandom_range(0, 1));
            addr[p]  = ($urandom_range(0, 15) == 0) ? 32'h8000_0003 : 32'($urandom_range(0, 10));
            wdata[p] = $urandom;
            req[p]   = 1'b1;
            t = 0;
            do begin
                tick();
                t++;
            end while (!ack[p] && t < 40);
            check(p == 0 ? "rnd_ack0" : "rnd_ack1", ack[p], 1'b1);
            if (!ack[p]) begin
                req[p] = 1'b0;
                return;
            end
            tick();
        end
        req[p] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int b;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
            d3_req[p] = 1'b0; d3_we[p] = 1'b0; d3_addr[p] = '0; d3_wdata[p] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        mem_init = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_re", mem_re, 1'b0);
        check("rst_ack0", ack[0], 1'b0);
        check("rst_ack1", ack[1], 1'b0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_rd0", rdata[0], 32'd0);
        rst = 1'b0;
        tick();

        // Port 0 write, then port 1 reads it back.
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'd3; wdata[0] = 32'hDEAD_BEEF;
        tick();
        check("wr_we_c1", mem_we, 1'b1);
        check("wr_addr_c1", mem_addr, 32'd3);
        check("wr_wdata_c1", mem_wdata, 32'hDEAD_BEEF);
        tick();
        check("wr_ack_c2", ack[0], 1'b1);
        check("wr_err_c2", err[0], 1'b0);
        check("wr_we_c2", mem_we, 1'b0);
        req[0] = 1'b0;
        tick();
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'd3;
        tick();
        check("rd_re_c1", mem_re, 1'b1);
        tick();
        check("rd_ack_c2", ack[1], 1'b1);
        check("rd_data_c2", rdata[1], 32'hDEAD_BEEF);
        req[1] = 1'b0;
        tick();

        // Out-of-range read on port 1.
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'd8;
        tick();
        check("oor_strobe_c1", {mem_we, mem_re}, 2'b00);
        tick();
        check("oor_ack_c2", ack[1], 1'b1);
        check("oor_err_c2", err[1], 1'b1);
        check("oor_rd_kept", rdata[1], 32'hDEAD_BEEF);
        req[1] = 1'b0;
        tick();

        // Both ports keep requesting reads: grants alternate.
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'd1;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'd6;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!(ack[0] || ack[1]) && n < 10);
            check("alt_winner", ack[1], (t % 2 == 1));
            check("alt_single", ack[0] ^ ack[1], 1'b1);
            if (ack[0]) check("alt_rd0", rdata[0], 32'hA000_0001);
            else        check("alt_rd1", rdata[1], 32'hA000_0006);
        end
        req[0] = 1'b0; req[1] = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            b = grant_log[grant_log.size() - 4 + k];
            check("model_grant_seq", b, k % 2);
        end

        // Port 0 holds req across its ack while port 1 arrives during RESP.
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'd2;
        tick();
        tick();
        check("hold_ack0_c2", ack[0], 1'b1);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'd7;
        tick();
        tick();
        tick();
        check("hold_ack1_c5", ack[1], 1'b1);
        check("hold_noack0_c5", ack[0], 1'b0);
        check("hold_rd1", rdata[1], 32'hA000_0007);
        req[1] = 1'b0;
        tick();
        tick();
        tick();
        check("hold_ack0_c8", ack[0], 1'b1);
        check("hold_rd0", rdata[0], 32'hA000_0002);
        req[0] = 1'b0;
        tick();

        // Reset in the middle of a write's ACCESS cycle.
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'd4; wdata[0] = 32'h5555_5555;
        tick();
        check("mid_we_before", mem_we, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_we_async", mem_we, 1'b0);
        check("mid_busy_async", busy, 1'b0);
        req[0] = 1'b0;
        tick();
        check("mid_no_ack", ack[0], 1'b0);
        rst = 1'b0;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'd4;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'd5;
        tick();
        tick();
        check("post_rst_p0_first", ack[0], 1'b1);
        check("post_rst_p1_wait", ack[1], 1'b0);
        check("post_rst_no_write", rdata[0], 32'hA000_0004);
        req[0] = 1'b0;
        tick();
        tick();
        tick();
        check("post_rst_ack1", ack[1], 1'b1);
        check("post_rst_rd1", rdata[1], 32'hA000_0005);
        req[1] = 1'b0;
        tick();

        fork
            drive(0, 40);
            drive(1, 40);
        join
        repeat (4) tick();

        // Three-cycle read latency on the second instance.
        d3_req[0] = 1'b1; d3_we[0] = 1'b0; d3_addr[0] = 32'd5;
        tick();
        check("lat3_re_c1", d3_mre, 1'b1);
        tick();
        check("lat3_re_c2", d3_mre, 1'b1);
        tick();
        check("lat3_re_c3", d3_mre, 1'b1);
        check("lat3_noack_c3", d3_ack[0], 1'b0);
        tick();
        check("lat3_ack_c4", d3_ack[0], 1'b1);
        check("lat3_rd_c4", d3_rdata[0], 32'h1234_5678);
        check("lat3_re_c4", d3_mre, 1'b0);
        check("lat3_err_c4", d3_err[0], 1'b0);
        check("lat3_we", d3_mwe, 1'b0);
        d3_req[0] = 1'b0;
        tick();
        check("lat3_idle", d3_busy, 1'b0);
        check("lat3_p1_quiet", {d3_ack[1], d3_err[1]}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", chk, errs);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the word-addressed data memory between two requesters.
  - Port 0: CPU load/store path.
  - Port 1: test/DMA loader.
- Sits between the requesters and the data memory instance. It owns the memory's address, write-data, MemWrite and MemRead strobes.
- Provides a registered req/ack handshake, fair round-robin arbitration and out-of-range address checking.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, requester address width (word index).
- MEM_DEPTH, 8, number of memory words; addresses >= MEM_DEPTH are illegal.
- RD_LAT, 1, cycles mem_re_o is held before mem_rdata_i is sampled (1..4).

Ports:
- clk_i, in, 1: single clock, rising edge.
- rst_i, in, 1: asynchronous, active-high reset.
- m0_req_i, in, 1: port 0 request; held with m0_we_i/addr/wdata stable until m0_ack_o.
- m0_we_i, in, 1: 1 = write, 0 = read.
- m0_addr_i, in, ADDR_W: word address.
- m0_wdata_i, in, DATA_W: write data.
- m0_ack_o, out, 1: one-cycle completion pulse.
- m0_rdata_o, out, DATA_W: read data, valid while m0_ack_o=1, held afterwards.
- m0_err_o, out, 1: with ack, address out of range.
- m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_ack_o, m1_rdata_o, m1_err_o: same as port 0.
- mem_addr_o, out, ADDR_W: memory address.
- mem_wdata_o, out, DATA_W: memory write data.
- mem_we_o, out, 1: MemWrite strobe.
- mem_re_o, out, 1: MemRead strobe.
- mem_rdata_i, in, DATA_W: memory read data (combinational from mem_addr_o).
- busy_o, out, 1: high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = 1, so port 0 wins the first contention.
- Reset mid-operation forces all of the above immediately. The strobes drop asynchronously and the in-flight ack is never issued; the requester must re-issue.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any req_i is high, pick a winner. Latch its index, we, addr and wdata into registers, update last_grant, then go to ACCESS.
  - With no request, stay in IDLE.
  - Round robin: if both ports request, the port not equal to last_grant wins. A single requester always wins.
- ACCESS:
  - mem_addr_o/mem_wdata_o are driven from the latched registers throughout the state.
  - Legal write: mem_we_o=1 for exactly 1 cycle, then RESP.
  - Legal read: mem_re_o=1 for RD_LAT cycles, using a counter 0..RD_LAT-1. mem_rdata_i is captured into the winner's rdata register on the last cycle, then RESP.
  - Illegal address (addr >= MEM_DEPTH): no strobe asserted; spend 1 cycle, set the error flag, then RESP.
- RESP:
  - Winner's ack_o=1 for 1 cycle; err_o=1 in that cycle if the address was illegal; then IDLE.
  - The loser's ack/err stay 0.
- Latency, with request first seen high at edge 0:
  - Write or illegal access: ack during cycle 2.
  - Read: ack during cycle 1+RD_LAT.
  - Minimum IDLE-to-IDLE: 3 cycles.
- A req still high in the cycle after ack is treated as a new request; requesters drop req on seeing ack.
- A request arriving while busy_o=1 waits; it is evaluated in the next IDLE.
- mem_we_o and mem_re_o are never both 1. Neither strobe is asserted outside ACCESS.
- mem_addr_o/mem_wdata_o hold their last value while IDLE (no toggling).
- m*_rdata_o of a port updates only on that port's legal read.
- Widths: the address compare is unsigned over the full ADDR_W; no truncation.

Decomposition:
- Package dmem_arb_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), port index constants P0/P1, default MEM_DEPTH and RD_LAT.
- One sub-module, rr_arb2:
  - Pure 2-way round-robin grant logic.
  - Inputs: req[1:0], last_grant. Outputs: grant index, grant_valid.
  - Combinational, instantiated once.

Test Plan:
- Port 0 writes addr 3 data 0xDEADBEEF:
  - mem_we_o high exactly cycle 1 with mem_addr_o=3 and mem_wdata_o=0xDEADBEEF.
  - m0_ack_o pulses in cycle 2 with m0_err_o=0.
  - A subsequent port 1 read of addr 3 returns m1_rdata_o=0xDEADBEEF with ack in cycle 2.
- Both ports request reads simultaneously and keep re-requesting after each ack, for 4 transactions:
  - Grants alternate P0, P1, P0, P1.
  - Acks never coincide, and each port's rdata matches its own address.
- Port 1 reads addr 8 (MEM_DEPTH=8):
  - No mem_re_o/mem_we_o assertion.
  - m1_ack_o and m1_err_o both 1 in cycle 2; m1_rdata_o unchanged.
- RD_LAT=3, port 0 reads addr 5 holding 0x12345678:
  - mem_re_o high cycles 1-3.
  - m0_ack_o in cycle 4 with m0_rdata_o=0x12345678.
- rst_i asserted mid-ACCESS of a write:
  - mem_we_o drops to 0 immediately (before the next edge).
  - No ack issued; busy_o=0; state IDLE.
  - After release, port 0 wins first arbitration against port 1.
- Port 0 keeps req high across ack while port 1 requests during RESP:
  - The next grant goes to port 1 (round robin).
  - Port 0 is served afterwards; no lost or duplicated acks.
